dphy_hs_tx_lane_seq: RTL and testbench
======================================

Name: dphy_hs_tx_lane_seq

Overview:
- Byte-clock-domain transmit sequencer for one D-PHY data lane of the MIPI PHY macro. It is the TX counterpart of the lane's deserializer/sync-detect path.
- Converts a valid/ready byte stream into the full D-PHY HS burst on the lane's LP/HS control pins:
  - LP-11 → LP-01 → LP-00 (HS prepare)
  - HS-zero, then sync byte 0xB8
  - payload
  - HS-trail, then LP-11 exit
- One instance per data lane; outputs connect to the lane's Dn_DTXLPP/DTXLPN/TXLPEN/TXHSPD/TXHSEN/HS_SER_EN/HSTX_DATA pins.

Parameters:
- T_LPX, 4, LP-01 duration in BYTECLK cycles (1..255)
- T_PREPARE, 3, LP-00 HS-prepare duration in cycles (1..255)
- T_ZERO, 10, HS-zero (0x00 bytes) duration in cycles (1..255)
- T_TRAIL, 6, HS-trail duration in cycles (1..255)
- T_EXIT, 8, LP-11 hold after the burst before returning to IDLE (1..255)

Ports:
- BYTECLK  in  1  HS byte clock (the PHY's byte clock output)
- RST  in  1  asynchronous reset, active-high
- TX_REQ  in  1  burst request, sampled in IDLE
- TX_DATA  in  8  payload byte
- TX_VALID  in  1  TX_DATA valid
- TX_LAST  in  1  marks the final payload byte
- TX_READY  out  1  byte accepted when TX_VALID&TX_READY
- DTXLPP  out  1  LP driver P level
- DTXLPN  out  1  LP driver N level
- TXLPEN  out  1  LP driver enable
- TXHSPD  out  1  HS driver power-down
- TXHSEN  out  1  HS driver enable
- HS_SER_EN  out  1  serializer enable
- HSTX_DATA  out  8  byte to serializer (bit0 serialized first)
- BUSY  out  1  high whenever state != IDLE
- TX_DONE  out  1  one-cycle pulse on return to IDLE
- ERR_UNDERFLOW  out  1  one-cycle pulse, payload underflow

Behaviour:
- Clocking and outputs:
  - Single clock BYTECLK; RST is asynchronous, active-high.
  - All outputs except TX_READY are registered and update on the same edge as the state register.
  - TX_READY is combinational from state and flags.
- Reset values (also forced immediately on RST assertion mid-burst): DTXLPP=1, DTXLPN=1, TXLPEN=1, TXHSPD=1, TXHSEN=0, HS_SER_EN=0, HSTX_DATA=0x00, TX_READY=0, BUSY=0, TX_DONE=0, ERR_UNDERFLOW=0, state=IDLE.
- Per-state outputs, given as {LPP, LPN, LPEN, HSPD, HSEN, SER_EN}:
  - IDLE: {1,1,1,1,0,0}. When TX_REQ is sampled high, go to LPX.
  - LPX: {0,1,1,1,0,0} for T_LPX cycles, then PREP.
  - PREP: {0,0,1,0,0,0} for T_PREPARE cycles, then ZERO.
  - ZERO: {0,0,0,0,1,1}, HSTX_DATA=0x00, for T_ZERO cycles, then SYNC.
  - SYNC: same control bits, HSTX_DATA=0xB8, one cycle, then DATA.
  - DATA: same control bits. HSTX_DATA holds the most recently accepted byte.
  - TRAIL: same control bits. HSTX_DATA = {8{~b}}, where b is bit7 of the last byte driven (0xB8 if no payload byte was driven). Lasts T_TRAIL cycles, then EXIT.
  - EXIT: {1,1,1,1,0,0} for T_EXIT cycles, then IDLE with TX_DONE=1 for that first IDLE cycle.
- Handshake:
  - TX_READY=1 in SYNC and DATA until a TX_LAST byte has been accepted.
  - A byte accepted at cycle t appears on HSTX_DATA at t+1.
  - After the TX_LAST byte is accepted at t: TX_READY=0 from t+1, that byte is driven at t+1, and TRAIL starts at t+2.
- Underflow:
  - Condition: TX_READY=1 and TX_VALID=0 at cycle t.
  - ERR_UNDERFLOW=1 at t+1.
  - TRAIL starts at t+1 (first trail byte at t+1); TX_READY=0 from t+1.
  - TX_DATA is not consumed.
- Other boundary rules:
  - TX_REQ outside IDLE is ignored; there is no queuing.
  - TX_LAST without TX_VALID is ignored.
  - TX_REQ held high at TX_DONE starts a new burst: LPX on the next cycle.
  - Payload length is unbounded.
- Duration counters: 8-bit down-counters, loaded with (param−1) on state entry; the state advances when the counter is 0.

Test Plan:
1. Reset: assert RST mid-ZERO → same-cycle LP-11 outputs, TXHSEN=0, HSTX_DATA=0x00, BUSY=0. After release, IDLE holds with TX_REQ=0.
2. Nominal burst with default params: TX_REQ@0, bytes 0x11/0x22/0x83 valid from cycle 18, LAST on 0x83.
   - Control outputs: LPX 1–4 (LPP=0), PREP 5–7 (LP-00, TXHSPD=0), ZERO 8–17 (HSTX=0x00).
   - HSTX_DATA: 0xB8@18, 0x11@19, 0x22@20, 0x83@21, trail 0x00@22–27.
   - Exit: EXIT 28–35 LP-11; TX_DONE@36.
3. Underflow: one byte 0x7F accepted @18, TX_VALID=0 @19 → ERR_UNDERFLOW@20, HSTX=0x7F@19, trail 0xFF@20–25, TX_DONE@34.
4. Backpressure-free stall: TX_VALID low in SYNC @18 → ERR_UNDERFLOW@19, trail 0x00@19–24 (last byte 0xB8).
5. Back-to-back bursts: TX_REQ held high → second LPX begins the cycle after TX_DONE. TX_REQ pulses during DATA/EXIT produce no extra burst.
6. Parameter corner: all params=1, single byte 0xA5 with LAST → LPX, PREP and ZERO last one cycle each. HSTX_DATA: 0xB8, 0xA5, then one 0x00 trail byte; one EXIT cycle, then TX_DONE.

Source files
------------

// File: rtl/dphy_hs_tx_lane_seq.sv
// dphy_hs_tx_lane_seq: D-PHY data-lane HS burst sequencer (LP-11/01/00, HS-zero, sync, payload, trail, exit)
module dphy_hs_tx_lane_seq #(
  parameter int T_LPX     = 4,
  parameter int T_PREPARE = 3,
  parameter int T_ZERO    = 10,
  parameter int T_TRAIL   = 6,
  parameter int T_EXIT    = 8
) (
  input  logic       i_byteclk,
  input  logic       i_rst,
  input  logic       i_tx_req,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  input  logic       i_tx_last,
  output logic       o_tx_ready,
  output logic       o_dtxlpp,
  output logic       o_dtxlpn,
  output logic       o_txlpen,
  output logic       o_txhspd,
  output logic       o_txhsen,
  output logic       o_hs_ser_en,
  output logic [7:0] o_hstx_data,
  output logic       o_busy,
  output logic       o_tx_done,
  output logic       o_err_underflow
);
  typedef enum logic [2:0] {S_IDLE, S_LPX, S_PREP, S_ZERO, S_SYNC, S_DATA, S_TRAIL, S_EXIT} state_t;
  localparam logic [5:0] C_LP11 = 6'b111100;
  localparam logic [5:0] C_LPX  = 6'b011100;
  localparam logic [5:0] C_PREP = 6'b001000;
  localparam logic [5:0] C_HS   = 6'b000011;
  localparam logic [7:0] SYNC_BYTE = 8'hB8;
  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_data;
  logic [5:0] r_ctrl;
  logic       r_last;
  logic       r_busy;
  logic       r_done;
  logic       r_err;
  logic       w_cnt_zero;
  logic       w_ready;
  assign w_cnt_zero = r_cnt == 8'd0;
  assign w_ready = (r_state == S_SYNC) || (r_state == S_DATA && !r_last);
  assign o_tx_ready = w_ready;
  assign {o_dtxlpp, o_dtxlpn, o_txlpen, o_txhspd, o_txhsen, o_hs_ser_en} = r_ctrl;
  assign o_hstx_data = r_data;
  assign o_busy = r_busy;
  assign o_tx_done = r_done;
  assign o_err_underflow = r_err;
  // Burst sequencer: state, duration counter and all registered lane outputs
  always_ff @(posedge i_byteclk or posedge i_rst)
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_data  <= 8'h00;
      r_ctrl  <= C_LP11;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE:
          if (i_tx_req) begin
            r_state <= S_LPX;
            r_cnt   <= 8'(T_LPX - 1);
            r_ctrl  <= C_LPX;
            r_busy  <= 1'b1;
          end
        S_LPX:
          if (w_cnt_zero) begin
            r_state <= S_PREP;
            r_cnt   <= 8'(T_PREPARE - 1);
            r_ctrl  <= C_PREP;
          end else r_cnt <= r_cnt - 8'd1;
        S_PREP:
          if (w_cnt_zero) begin
            r_state <= S_ZERO;
            r_cnt   <= 8'(T_ZERO - 1);
            r_ctrl  <= C_HS;
            r_data  <= 8'h00;
          end else r_cnt <= r_cnt - 8'd1;
        S_ZERO:
          if (w_cnt_zero) begin
            r_state <= S_SYNC;
            r_data  <= SYNC_BYTE;
            r_last  <= 1'b0;
          end else r_cnt <= r_cnt - 8'd1;
        S_SYNC, S_DATA:
          if (w_ready && i_tx_valid) begin
            r_state <= S_DATA;
            r_data  <= i_tx_data;
            r_last  <= i_tx_last;
          end else begin
            r_state <= S_TRAIL;
            r_err   <= w_ready;
            r_data  <= {8{~r_data[7]}};
            r_cnt   <= 8'(T_TRAIL - 1);
          end
        S_TRAIL:
          if (w_cnt_zero) begin
            r_state <= S_EXIT;
            r_cnt   <= 8'(T_EXIT - 1);
            r_ctrl  <= C_LP11;
            r_data  <= 8'h00;
          end else r_cnt <= r_cnt - 8'd1;
        S_EXIT:
          if (w_cnt_zero) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else r_cnt <= r_cnt - 8'd1;
      endcase
    end
endmodule

// File: tb/tb_dphy_hs_tx_lane_seq.sv
// tb_dphy_hs_tx_lane_seq: timeline-model bench for the D-PHY HS lane sequencer (default and all-1 timing)
module tb_dphy_hs_tx_lane_seq;
  localparam int N = 2000;
  localparam logic [5:0] LP11 = 6'b111100;
  localparam logic [5:0] HS   = 6'b000011;
  typedef struct packed {logic [5:0] c; logic [7:0] d; logic rdy; logic busy; logic done; logic err;} exp_t;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic req [2];
  logic vld [2];
  logic lst [2];
  logic [7:0] dat [2];
  logic rdy [2], lpp [2], lpn [2], lpen [2], hspd [2], hsen [2], ser [2], busy [2], done [2], err [2];
  logic [7:0] hs [2];
  logic sr [2][N];
  logic sv [2][N];
  logic sl [2][N];
  logic [7:0] sd [2][N];
  exp_t ex [2][N];
  exp_t act;
  int vectors = 0;
  int miscompares = 0;
  bit run = 0;
  int cyc = 0;

  dphy_hs_tx_lane_seq u0 (
    .i_byteclk(clk), .i_rst(rst), .i_tx_req(req[0]), .i_tx_data(dat[0]), .i_tx_valid(vld[0]), .i_tx_last(lst[0]),
    .o_tx_ready(rdy[0]), .o_dtxlpp(lpp[0]), .o_dtxlpn(lpn[0]), .o_txlpen(lpen[0]), .o_txhspd(hspd[0]),
    .o_txhsen(hsen[0]), .o_hs_ser_en(ser[0]), .o_hstx_data(hs[0]), .o_busy(busy[0]), .o_tx_done(done[0]),
    .o_err_underflow(err[0]));

  dphy_hs_tx_lane_seq #(.T_LPX(1), .T_PREPARE(1), .T_ZERO(1), .T_TRAIL(1), .T_EXIT(1)) u1 (
    .i_byteclk(clk), .i_rst(rst), .i_tx_req(req[1]), .i_tx_data(dat[1]), .i_tx_valid(vld[1]), .i_tx_last(lst[1]),
    .o_tx_ready(rdy[1]), .o_dtxlpp(lpp[1]), .o_dtxlpn(lpn[1]), .o_txlpen(lpen[1]), .o_txhspd(hspd[1]),
    .o_txhsen(hsen[1]), .o_hs_ser_en(ser[1]), .o_hstx_data(hs[1]), .o_busy(busy[1]), .o_tx_done(done[1]),
    .o_err_underflow(err[1]));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic put(input int k, input int t, input logic [5:0] c, input logic [7:0] d);
    if (t < N) begin
      ex[k][t].c = c;
      ex[k][t].d = d;
      ex[k][t].busy = 1'b1;
      ex[k][t].rdy = 1'b0;
    end
  endtask

  // Expected lane timeline: each burst laid out phase by phase from the request cycle
  task automatic build(input int k, input int tl, input int tp, input int tz, input int tt, input int te);
    int t;
    int p;
    logic [7:0] lb;
    for (int i = 0; i < N; i++) ex[k][i] = {LP11, 8'h00, 4'b0000};
    t = 0;
    while (t < N) begin
      if (!sr[k][t]) begin
        t++;
        continue;
      end
      p = t + 1;
      for (int i = 0; i < tl; i++) begin put(k, p, 6'b011100, 8'h00); p++; end
      for (int i = 0; i < tp; i++) begin put(k, p, 6'b001000, 8'h00); p++; end
      for (int i = 0; i < tz; i++) begin put(k, p, HS, 8'h00); p++; end
      lb = 8'hB8;
      put(k, p, HS, lb);
      while (p < N) begin
        ex[k][p].rdy = 1'b1;
        if (sv[k][p]) begin
          lb = sd[k][p];
          put(k, p + 1, HS, lb);
          p++;
          if (sl[k][p-1]) begin
            p++;
            break;
          end
        end else begin
          p++;
          if (p < N) ex[k][p].err = 1'b1;
          break;
        end
      end
      for (int i = 0; i < tt; i++) begin put(k, p, HS, {8{~lb[7]}}); p++; end
      for (int i = 0; i < te; i++) begin put(k, p, LP11, 8'h00); p++; end
      if (p < N) ex[k][p].done = 1'b1;
      t = p;
    end
  endtask

  task automatic drive(input int c);
    for (int k = 0; k < 2; k++) begin
      req[k] = sr[k][c];
      vld[k] = sv[k][c];
      lst[k] = sl[k][c];
      dat[k] = sd[k][c];
    end
  endtask

  // Cycle-by-cycle comparison of both lanes against the timeline model
  always @(negedge clk)
    if (run)
      for (int k = 0; k < 2; k++) begin
        act = {lpp[k], lpn[k], lpen[k], hspd[k], hsen[k], ser[k], hs[k], rdy[k], busy[k], done[k], err[k]};
        vectors++;
        if (act !== ex[k][cyc]) begin
          miscompares++;
          $display("FAIL lane%0d cycle %0d: got ctl=%b data=%h rdy=%b busy=%b done=%b err=%b, want ctl=%b data=%h rdy=%b busy=%b done=%b err=%b",
                   k, cyc, act.c, act.d, act.rdy, act.busy, act.done, act.err,
                   ex[k][cyc].c, ex[k][cyc].d, ex[k][cyc].rdy, ex[k][cyc].busy, ex[k][cyc].done, ex[k][cyc].err);
        end
      end

  initial begin
    for (int k = 0; k < 2; k++) begin
      req[k] = 0; vld[k] = 0; lst[k] = 0; dat[k] = 0;
      for (int t = 0; t < N; t++) begin sr[k][t] = 0; sv[k][t] = 0; sl[k][t] = 0; sd[k][t] = 0; end
    end
    sr[0][0] = 1;
    sv[0][18] = 1; sd[0][18] = 8'h11;
    sv[0][19] = 1; sd[0][19] = 8'h22;
    sv[0][20] = 1; sd[0][20] = 8'h83; sl[0][20] = 1;
    sr[0][40] = 1;
    sv[0][58] = 1; sd[0][58] = 8'h7F;
    sr[0][80] = 1;
    for (int t = 120; t <= 186; t++) sr[0][t] = 1;
    sr[0][60] = 1; sr[0][70] = 1;
    sr[1][0] = 1;
    sv[1][4] = 1; sd[1][4] = 8'hA5; sl[1][4] = 1;
    for (int t = 20; t <= 40; t++) sr[1][t] = 1;
    for (int k = 0; k < 2; k++)
      for (int t = 240; t < N - 80; t++) begin
        sr[k][t] = $urandom_range(0, 9) == 0;
        sv[k][t] = $urandom_range(0, 15) != 0;
        sl[k][t] = $urandom_range(0, 7) == 0;
        sd[k][t] = 8'($urandom);
      end
    build(0, 4, 3, 10, 6, 8);
    build(1, 1, 1, 1, 1, 1);
    chk("model_nom_lpx", ex[0][1].c, 6'b011100);
    chk("model_nom_prep", ex[0][5].c, 6'b001000);
    chk("model_nom_zero", {ex[0][17].c, ex[0][17].d}, {HS, 8'h00});
    chk("model_nom_sync", ex[0][18].d, 8'hB8);
    chk("model_nom_b0", ex[0][19].d, 8'h11);
    chk("model_nom_b2", {ex[0][21].d, 7'd0, ex[0][21].rdy}, {8'h83, 8'h00});
    chk("model_nom_trail", {ex[0][22].d, ex[0][27].d, ex[0][27].c}, {16'h0000, HS});
    chk("model_nom_exit", {ex[0][28].c, 7'd0, ex[0][28].busy}, {LP11, 8'h01});
    chk("model_nom_done", ex[0][36].done, 1);
    chk("model_uf_byte", ex[0][59].d, 8'h7F);
    chk("model_uf_err", {ex[0][60].err, ex[0][60].d}, {1'b1, 8'hFF});
    chk("model_uf_trail_end", {ex[0][65].d, ex[0][66].c}, {8'hFF, LP11});
    chk("model_uf_done", ex[0][74].done, 1);
    chk("model_stall_err", {ex[0][99].err, ex[0][99].d, ex[0][104].c, ex[0][105].c}, {1'b1, 8'h00, HS, LP11});
    chk("model_stall_done", ex[0][113].done, 1);
    chk("model_b2b", {ex[0][153].done, ex[0][154].c, ex[0][154].busy}, {1'b1, 6'b011100, 1'b1});
    chk("model_min_seq", {ex[1][4].d, ex[1][5].d, ex[1][6].d, ex[1][6].c}, {8'hB8, 8'hA5, 8'h00, HS});
    chk("model_min_exit", {ex[1][7].c, ex[1][7].busy, ex[1][8].done}, {LP11, 2'b11});
    repeat (3) @(posedge clk);
    #1 rst = 0;
    cyc = 0;
    drive(0);
    run = 1;
    for (int c = 1; c < N; c++) begin
      @(posedge clk);
      #1 cyc = c;
      drive(c);
    end
    @(posedge clk);
    #1 run = 0;
    req[0] = 1;
    @(posedge clk);
    #1 req[0] = 0;
    repeat (9) @(posedge clk);
    #1 chk("rst_pre_in_zero", {hsen[0], lpen[0], busy[0]}, 3'b101);
    rst = 1;
    #1 chk("rst_lp11", {lpp[0], lpn[0], lpen[0], hspd[0], hsen[0], ser[0]}, LP11);
    chk("rst_data", hs[0], 8'h00);
    chk("rst_flags", {busy[0], rdy[0], done[0], err[0]}, 4'b0000);
    @(posedge clk);
    #1 rst = 0;
    repeat (4) begin
      @(posedge clk);
      #1 chk("rst_idle_hold", {lpp[0], lpn[0], lpen[0], hspd[0], hsen[0], ser[0], busy[0], done[0]}, {LP11, 2'b00});
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
